mem_bank: RTL

MEM_BANK -- requirements
Module: mem_bank

---
 rtl/mem_bank_pkg.sv | 19 +
 rtl/mem_bank_rdpipe.sv | 35 +++
 rtl/mem_bank.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/mem_bank_pkg.sv
// Shared types for the mem_bank word memory: error causes and controller states.
package mem_bank_pkg;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_RD_LIMIT = 2'd1,
    ERR_WR_LIMIT = 2'd2,
    ERR_ALIGN    = 2'd3
  } err_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } st_e;

  localparam int ADR_W = 32;
  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_bank_rdpipe.sv
// Read-return delay line: DEPTH register stages carrying a valid bit and data.
// Each stage only loads data when a valid beat enters it, so the output holds between beats.
module mem_bank_rdpipe #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  logic [DEPTH-1:0]  vld;
  logic [DATA_W-1:0] dat [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      vld <= '0;
      for (int i = 0; i < DEPTH; i++) dat[i] <= '0;
    end else begin
      vld[0] <= in_valid;
      if (in_valid) dat[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
        vld[i] <= vld[i-1];
        if (vld[i-1]) dat[i] <= dat[i-1];
      end
    end
  end

  assign out_valid = vld[DEPTH-1];
  assign out_data  = dat[DEPTH-1];

endmodule

// File: rtl/mem_bank.sv
// Single-port-per-direction word memory with limit/alignment checking, sticky error capture,
// optional post-access stall and RD_LAT read latency. Macro MEM_BANK_BYTE_EN enables byte writes.
module mem_bank
  import mem_bank_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 256,
  parameter int ADR_LIMIT = 64,
  parameter int RD_LAT    = 1,
  parameter int WAIT_CYC  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADR_W-1:0]  add_r,
  input  logic [ADR_W-1:0]  add_w,
  input  logic [DATA_W-1:0] data_w,
  input  logic [DATA_W/8-1:0] be,
  input  logic              rd,
  input  logic              wr,
  output logic [DATA_W-1:0] data_r,
  output logic              rd_valid,
  output logic              req,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADR_W-1:0]  err_adr,
  input  logic              err_clr
);

  localparam int BPW = DATA_W / 8;
  localparam int AW  = $clog2(BPW);
  localparam int IW  = $clog2(DEPTH);
  localparam logic [ADR_W-1:0] LIMIT_B = ADR_W'(ADR_LIMIT * BPW);
  localparam logic [ADR_W-1:0] DEPTH_W = ADR_W'(DEPTH);
  localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYC);

  st_e              state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             accept, rd_acc, wr_acc;
  logic             rd_oob, rd_mis, rd_bad, wr_oob, wr_mis, wr_bad;
  err_e             rd_code, wr_code, new_code, err_code_q;
  logic             new_err;
  logic [ADR_W-1:0] new_adr;
  logic [IW-1:0]    rd_idx, wr_idx;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] mem [DEPTH];

  assign accept = !reset && (state == ST_IDLE) && (rd || wr);
  assign rd_acc = accept && rd;
  assign wr_acc = accept && wr;

  // An address past the physical array is treated like one past the legal limit.
  assign rd_oob  = (add_r >= LIMIT_B) || ((add_r >> AW) >= DEPTH_W);
  assign wr_oob  = (add_w >= LIMIT_B) || ((add_w >> AW) >= DEPTH_W);
  assign rd_mis  = (add_r[AW-1:0] != '0);
  assign wr_mis  = (add_w[AW-1:0] != '0);
  assign rd_bad  = rd_oob || rd_mis;
  assign wr_bad  = wr_oob || wr_mis;
  assign rd_code = rd_oob ? ERR_RD_LIMIT : ERR_ALIGN;
  assign wr_code = wr_oob ? ERR_WR_LIMIT : ERR_ALIGN;
  assign rd_idx  = add_r[AW +: IW];
  assign wr_idx  = add_w[AW +: IW];

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // FSM: next state
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      ST_IDLE: begin
        if (accept && (WAIT_CYC != 0)) begin
          state_nx = ST_BUSY;
          cnt_nx   = WAIT_LD;
        end
      end
      ST_BUSY: begin
        cnt_nx = cnt - CNT_W'(1);
        if (cnt <= CNT_W'(1)) state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // FSM: outputs
  always_comb begin
    req = (state == ST_BUSY);
  end

  // Memory array has no reset so committed data survives a reset pulse.
  always_ff @(posedge clk) begin
    if (wr_acc && !wr_bad) begin
`ifdef MEM_BANK_BYTE_EN
      for (int b = 0; b < BPW; b++) begin
        if (be[b]) mem[wr_idx][b*8 +: 8] <= data_w[b*8 +: 8];
      end
`else
      mem[wr_idx] <= data_w;
`endif
    end
  end

`ifndef MEM_BANK_BYTE_EN
  logic be_unused;
  assign be_unused = ^be;
`endif

  // Sampled before the same-edge write lands, giving read-before-write ordering.
  assign rd_word = rd_bad ? '0 : mem[rd_idx];

  mem_bank_rdpipe #(
    .DATA_W (DATA_W),
    .DEPTH  (RD_LAT)
  ) u_rdpipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (rd_acc),
    .in_data   (rd_word),
    .out_valid (rd_valid),
    .out_data  (data_r)
  );

  // Read error wins when both sides fault in the same cycle.
  assign new_err  = (rd_acc && rd_bad) || (wr_acc && wr_bad);
  assign new_code = (rd_acc && rd_bad) ? rd_code : wr_code;
  assign new_adr  = (rd_acc && rd_bad) ? add_r : add_w;

  always_ff @(posedge clk) begin
    if (reset) begin
      err        <= 1'b0;
      err_code_q <= ERR_NONE;
      err_adr    <= '0;
    end else if (new_err && (err_clr || !err)) begin
      err        <= 1'b1;
      err_code_q <= new_code;
      err_adr    <= new_adr;
    end else if (err_clr) begin
      err        <= 1'b0;
      err_code_q <= ERR_NONE;
      err_adr    <= '0;
    end
  end

  assign err_code = err_code_q;

endmodule
